// File: rtl/disp_scheduler_if.sv
// disp_scheduler_if: groups the digit-source inputs, the per-source request
// lines and the scanned display outputs of disp_scheduler into one bundle.
// The slave modport is the scheduler's view. The master modport is the view of
// whatever drives the sources and watches the display pins.
interface disp_scheduler_if;
  logic [2:0]  req;
  logic [23:0] src0_bcd;
  logic [23:0] src1_bcd;
  logic [23:0] src2_bcd;
  logic [2:0]  src0_cur;
  logic [2:0]  src1_cur;
  logic [2:0]  src2_cur;
  logic [2:0]  grant;
  logic        frame_tick;
  logic [7:0]  seg_com;
  logic [7:0]  seg_data;

  modport master (
    output req, src0_bcd, src1_bcd, src2_bcd, src0_cur, src1_cur, src2_cur,
    input  grant, frame_tick, seg_com, seg_data
  );

  modport slave (
    input  req, src0_bcd, src1_bcd, src2_bcd, src0_cur, src1_cur, src2_cur,
    output grant, frame_tick, seg_com, seg_data
  );
endinterface

// File: rtl/disp_scheduler.sv
// disp_scheduler: time-multiplexed owner of the 6-digit seven-segment display.
// Three BCD sources compete for the display (src2 > src1 > src0, where src0 is
// the fallback). Ownership changes only when the 8-slot scan frame wraps. A
// granted owner is protected from higher-priority preemption for HOLD_FRAMES
// frames. Slots 0-5 drive digits 0-5, and slots 6-7 are blank so that a frame
// is always 8 slots long. The owner's cursor digit blinks at BLINK_HALF cycles
// per half-period.
// Optional feature: define DISP_DP_SEP_EN to light the decimal point on
// digits 1 and 3, which gives HH.MM.SS separators.
module disp_scheduler #(
  parameter int SCAN_DIV    = 1,
  parameter int HOLD_FRAMES = 4,
  parameter int BLINK_HALF  = 500
) (
  input  logic              clk,
  input  logic              rst,
  disp_scheduler_if.slave   bus
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int BLK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_HALF - 1);

  // BCD to {a,b,c,d,e,f,g,dp}. Codes 10-15 are not digits and show blank.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        s_cnt_q, s_cnt_d;
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic [2:0]        grant_q, grant_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              frame_tick_q, frame_tick_d;
  logic [7:0]        seg_com_q, seg_com_d;
  logic [7:0]        seg_data_q, seg_data_d;

  logic              slot_end_s;
  logic              wrap_s;
  logic [2:0]        req_eff_s;
  logic [2:0]        pick_s;
  logic [2:0]        next_owner_s;
  logic              owner_req_s;
  logic [23:0]       own_bcd_s;
  logic [2:0]        own_cur_s;
  logic [3:0]        digit_s;
  logic [7:0]        com_s;
  logic              active_s;
  logic [7:0]        seg_s;

  // Scan divider, slot counter and free-running blink timer.
  always_comb begin
    slot_end_s  = (div_q == DIV_LAST);
    wrap_s      = slot_end_s && (s_cnt_q == 3'd7);
    div_d       = div_q;
    s_cnt_d     = s_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (slot_end_s) begin
      div_d   = {DIV_W{1'b0}};
      s_cnt_d = s_cnt_q + 3'd1;
    end else begin
      div_d   = div_q + DIV_W'(1);
    end
    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = {BLK_W{1'b0}};
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
    end
  end

  // Frame-boundary arbitration with a hold-off against early preemption.
  always_comb begin
    // src0 requests at all times, so req[0] is overridden to 1.
    req_eff_s    = bus.req | 3'b001;
    owner_req_s  = |(req_eff_s & grant_q);
    pick_s       = 3'b001;
    next_owner_s = grant_q;
    grant_d      = grant_q;
    hold_d       = hold_q;
    frame_tick_d = wrap_s;
    if (req_eff_s[2]) begin
      pick_s = 3'b100;
    end else if (req_eff_s[1]) begin
      pick_s = 3'b010;
    end else begin
      pick_s = 3'b001;
    end
    // The owner is requesting, so pick_s can only be the owner or a higher
    // source. A lower-priority source therefore never preempts.
    if (!owner_req_s) begin
      next_owner_s = pick_s;
    end else if (hold_q >= HOLD_MAX) begin
      next_owner_s = pick_s;
    end else begin
      next_owner_s = grant_q;
    end
    if (wrap_s) begin
      grant_d = next_owner_s;
      if (next_owner_s != grant_q) begin
        hold_d = {HOLD_W{1'b0}};
      end else if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = hold_q;
      end
    end else begin
      grant_d = grant_q;
      hold_d  = hold_q;
    end
  end

  // Owner digit select, decode, separator and cursor blink for the current slot.
  always_comb begin
    case (grant_q)
      3'b010: begin
        own_bcd_s = bus.src1_bcd;
        own_cur_s = bus.src1_cur;
      end
      3'b100: begin
        own_bcd_s = bus.src2_bcd;
        own_cur_s = bus.src2_cur;
      end
      default: begin
        own_bcd_s = bus.src0_bcd;
        own_cur_s = bus.src0_cur;
      end
    endcase
    active_s = 1'b1;
    case (s_cnt_q)
      3'd0: begin com_s = 8'b0111_1111; digit_s = own_bcd_s[23:20]; end
      3'd1: begin com_s = 8'b1011_1111; digit_s = own_bcd_s[19:16]; end
      3'd2: begin com_s = 8'b1101_1111; digit_s = own_bcd_s[15:12]; end
      3'd3: begin com_s = 8'b1110_1111; digit_s = own_bcd_s[11:8];  end
      3'd4: begin com_s = 8'b1111_0111; digit_s = own_bcd_s[7:4];   end
      3'd5: begin com_s = 8'b1111_1011; digit_s = own_bcd_s[3:0];   end
      default: begin
        com_s    = 8'hFF;
        digit_s  = 4'd0;
        active_s = 1'b0;
      end
    endcase
    seg_s = bcd_to_seg(digit_s);
`ifdef DISP_DP_SEP_EN
    if ((s_cnt_q == 3'd1) || (s_cnt_q == 3'd3)) begin
      seg_s[0] = 1'b1;
    end else begin
      seg_s[0] = 1'b0;
    end
`endif
    if (!active_s) begin
      seg_s = 8'h00;
    end else if ((own_cur_s == s_cnt_q) && blink_ph_q) begin
      seg_s = 8'h00;
    end else begin
      seg_s = seg_s;
    end
    // Outputs are sampled once, at the first cycle of each slot.
    seg_com_d  = seg_com_q;
    seg_data_d = seg_data_q;
    if (div_q == {DIV_W{1'b0}}) begin
      seg_com_d  = com_s;
      seg_data_d = seg_s;
    end else begin
      seg_com_d  = seg_com_q;
      seg_data_d = seg_data_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= {DIV_W{1'b0}};
      s_cnt_q      <= 3'd0;
      blink_cnt_q  <= {BLK_W{1'b0}};
      blink_ph_q   <= 1'b0;
      grant_q      <= 3'b001;
      hold_q       <= {HOLD_W{1'b0}};
      frame_tick_q <= 1'b0;
      seg_com_q    <= 8'hFF;
      seg_data_q   <= 8'h00;
    end else begin
      div_q        <= div_d;
      s_cnt_q      <= s_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      grant_q      <= grant_d;
      hold_q       <= hold_d;
      frame_tick_q <= frame_tick_d;
      seg_com_q    <= seg_com_d;
      seg_data_q   <= seg_data_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.seg_com    = seg_com_q;
  assign bus.seg_data   = seg_data_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler: self-checking bench for disp_scheduler. It runs with
// SCAN_DIV=1, HOLD_FRAMES=4 and BLINK_HALF=500. A frame table gives the request
// pattern applied mid-frame and the owner expected after the wrap. Every slot's
// expected outputs go into a scoreboard queue and are compared when the DUT
// registers that slot.
module tb_disp_scheduler;
  localparam int BH = 500;

  typedef struct {
    logic [2:0] req_mid;
    logic [2:0] exp_grant;
  } fvec_t;

  typedef struct {
    logic [7:0] com;
    logic [7:0] data;
    logic       tick;
    logic [2:0] grant;
  } exp_t;

  logic clk;
  logic rst;
  disp_scheduler_if bus();

  disp_scheduler #(.SCAN_DIV(1), .HOLD_FRAMES(4), .BLINK_HALF(BH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         errors;
  int         checks;
  int         edge_n;
  int         blank_seen;
  int         steady_seen;
  int         frame_no;
  logic [7:0] seg_lut [16];
  logic [7:0] com_tab [8];
  fvec_t      fv [28];
  exp_t       sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset was released, used for the expected blink phase.
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected segment data for slot k of a frame, sampled after edge e.
  function automatic logic [7:0] exp_data(input logic [23:0] bcd, input logic [2:0] cur,
                                          input int k, input int e);
    logic [7:0] v;
    logic [3:0] d;
    if (k > 5) return 8'h00;
    d = bcd[(5 - k) * 4 +: 4];
    v = seg_lut[d];
`ifdef DISP_DP_SEP_EN
    if (k == 1 || k == 3) v[0] = 1'b1;
`endif
    if ((int'(cur) == k) && ((((e - 1) / BH) % 2) == 1)) v = 8'h00;
    return v;
  endfunction

  // One full frame under the owner. new_req is applied after slot 3, and
  // exp_next is the owner expected once the frame wraps.
  task automatic run_frame(input logic [2:0] owner, input logic [2:0] new_req,
                           input logic [2:0] exp_next);
    exp_t e;
    exp_t got;
    logic [23:0] bcd;
    logic [2:0] cur;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) bus.req = new_req;
      case (owner)
        3'b010:  begin bcd = bus.src1_bcd; cur = bus.src1_cur; end
        3'b100:  begin bcd = bus.src2_bcd; cur = bus.src2_cur; end
        default: begin bcd = bus.src0_bcd; cur = bus.src0_cur; end
      endcase
      e.com   = com_tab[k];
      e.data  = exp_data(bcd, cur, k, edge_n + 1);
      e.tick  = (k == 7);
      e.grant = (k == 7) ? exp_next : owner;
      sb.push_back(e);
      tick();
      got = sb.pop_front();
      chk($sformatf("com f%0d s%0d", frame_no, k), 32'(bus.seg_com), 32'(got.com));
      chk($sformatf("data f%0d s%0d", frame_no, k), 32'(bus.seg_data), 32'(got.data));
      chk($sformatf("tick f%0d s%0d", frame_no, k), 32'(bus.frame_tick), 32'(got.tick));
      chk($sformatf("grant f%0d s%0d", frame_no, k), 32'(bus.grant), 32'(got.grant));
      if (k == 2 && owner == 3'b001 && bus.src0_cur == 3'd2) begin
        if (bus.seg_data == 8'h00) blank_seen++;
        else                       steady_seen++;
      end
    end
    frame_no++;
  endtask

  initial begin
    logic [2:0] owner;
    errors = 0; checks = 0; frame_no = 0; blank_seen = 0; steady_seen = 0;
    seg_lut = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    com_tab = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFF, 8'hFF};
    // Frame table: {request applied mid-frame, owner after the wrap}.
    fv = '{
      '{3'b000, 3'b001}, '{3'b000, 3'b001}, '{3'b000, 3'b001}, '{3'b000, 3'b001},
      '{3'b010, 3'b010}, '{3'b000, 3'b001}, '{3'b000, 3'b001}, '{3'b000, 3'b001},
      '{3'b000, 3'b001}, '{3'b000, 3'b001}, '{3'b010, 3'b010}, '{3'b010, 3'b010},
      '{3'b110, 3'b010}, '{3'b110, 3'b010}, '{3'b110, 3'b010}, '{3'b110, 3'b100},
      '{3'b100, 3'b100}, '{3'b110, 3'b100}, '{3'b100, 3'b100}, '{3'b110, 3'b100},
      '{3'b000, 3'b001}, '{3'b001, 3'b001}, '{3'b100, 3'b001}, '{3'b000, 3'b001},
      '{3'b000, 3'b001}, '{3'b010, 3'b010}, '{3'b100, 3'b100}, '{3'b000, 3'b001}
    };

    bus.req = 3'b000;
    bus.src0_bcd = 24'h123456; bus.src1_bcd = 24'h987650; bus.src2_bcd = 24'h135790;
    bus.src0_cur = 3'd7; bus.src1_cur = 3'd7; bus.src2_cur = 3'd7;
    rst = 1'b1;
    tick();
    tick();
    chk("rst com", 32'(bus.seg_com), 32'hFF);
    chk("rst data", 32'(bus.seg_data), 32'h00);
    chk("rst grant", 32'(bus.grant), 32'h1);
    chk("rst tick", 32'(bus.frame_tick), 32'h0);
    rst = 1'b0;

    // Arbitration and scan patterns from the frame table.
    owner = 3'b001;
    for (int f = 0; f < 28; f++) begin
      run_frame(owner, fv[f].req_mid, fv[f].exp_grant);
      owner = fv[f].exp_grant;
    end

    // Cursor on digit 2: the span covers both blink phases.
    bus.src0_cur = 3'd2;
    for (int f = 0; f < 130; f++) run_frame(3'b001, 3'b000, 3'b001);
    chk("blink blanked", 32'(blank_seen > 0), 32'h1);
    chk("blink shown", 32'(steady_seen > 0), 32'h1);
    // Cursor 7 means no cursor: no blanking, even in the blink-on phase.
    bus.src0_cur = 3'd7;
    for (int f = 0; f < 70; f++) run_frame(3'b001, 3'b000, 3'b001);

    // Code 4'hB on digit 0 decodes to blank.
    bus.src0_bcd = 24'hB23456;
    run_frame(3'b001, 3'b000, 3'b001);
    bus.src0_bcd = 24'h123456;

    // Move ownership to src2, then apply reset mid-frame.
    run_frame(3'b001, 3'b100, 3'b100);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst com", 32'(bus.seg_com), 32'hFF);
    chk("midrst data", 32'(bus.seg_data), 32'h00);
    chk("midrst grant", 32'(bus.grant), 32'h1);
    chk("midrst tick", 32'(bus.frame_tick), 32'h0);
    bus.req = 3'b000;
    rst = 1'b0;
    // Scanning restarts at slot 0 under src0.
    run_frame(3'b001, 3'b000, 3'b001);
    run_frame(3'b001, 3'b000, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
